// File: rtl/axi_st_h2h_mlane_patchkr_pkg.sv
// Shared types and bit positions for the multi-lane AXIST pattern checker.
package axi_st_h2h_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam int STS_DONE_BIT = 0;
  localparam int STS_PASS_BIT = 1;
  localparam int FLG_OVF      = 0;
  localparam int FLG_TMO      = 1;

endpackage

// File: rtl/axi_st_h2h_mlane_patchkr_if.sv
// Checker bus: CSR controls, expected-data push side, received AXIST stream and results.
interface axi_st_h2h_mlane_patchkr_if #(
  parameter int AXI_CHNL_NUM = 4,
  parameter int CNT_WIDTH    = 9,
  parameter int TMO_WIDTH    = 16
);
  localparam int DW = 64 * AXI_CHNL_NUM;

  logic                    chk_en;
  logic [CNT_WIDTH-1:0]    chk_cnt;
  logic [AXI_CHNL_NUM-1:0] lane_mask;
  logic [TMO_WIDTH-1:0]    tmo_limit;
  logic [DW-1:0]           exp_din;
  logic                    exp_wr;
  logic                    exp_fifo_full;
  logic [DW-1:0]           axist_tdata;
  logic                    axist_tvalid;
  logic                    axist_tready;
  logic [1:0]              chk_status;
  logic [CNT_WIDTH-1:0]    beat_cnt;
  logic [CNT_WIDTH-1:0]    err_cnt;
  logic                    first_err_vld;
  logic [CNT_WIDTH-1:0]    first_err_idx;
  logic [AXI_CHNL_NUM-1:0] first_err_lane;
  logic [DW-1:0]           first_err_data;
  logic [1:0]              flags;

  modport master (
    output chk_en, chk_cnt, lane_mask, tmo_limit, exp_din, exp_wr, axist_tdata, axist_tvalid,
    input  exp_fifo_full, axist_tready, chk_status, beat_cnt, err_cnt, first_err_vld,
           first_err_idx, first_err_lane, first_err_data, flags
  );

  modport slave (
    input  chk_en, chk_cnt, lane_mask, tmo_limit, exp_din, exp_wr, axist_tdata, axist_tvalid,
    output exp_fifo_full, axist_tready, chk_status, beat_cnt, err_cnt, first_err_vld,
           first_err_idx, first_err_lane, first_err_data, flags
  );

endinterface

// File: rtl/axi_st_h2h_mlane_patchkr_fifo.sv
// Single-clock expected-data FIFO with synchronous clear and registered full/empty.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module axi_st_h2h_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count, w_count_next;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  assign w_pop  = i_rd & ~r_empty & ~i_clr;
  assign w_push = i_wr & (~r_full | w_pop) & ~i_clr;
  assign o_ovf  = i_wr & r_full & ~w_pop & ~i_clr;

  always_comb begin
    w_count_next = r_count;
    if (w_push & ~w_pop)
      w_count_next = r_count + 1'b1;
    else if (w_pop & ~w_push)
      w_count_next = r_count - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/axi_st_h2h_mlane_patchkr.sv
// Multi-lane AXIST pattern checker: compares received beats against buffered expected beats
// lane by lane and reports counts, first-error capture, timeout and pass/fail status.
module axi_st_h2h_mlane_patchkr
  import axi_st_h2h_chk_pkg::*;
#(
  parameter int AXI_CHNL_NUM   = 4,
  parameter int EXP_FIFO_DEPTH = 16,
  parameter int CNT_WIDTH      = 9,
  parameter int TMO_WIDTH      = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  axi_st_h2h_mlane_patchkr_if.slave bus
);
  localparam int DW = 64 * AXI_CHNL_NUM;

  chk_state_e              r_state, w_state_next;
  logic                    r_chk_en_d;
  logic [CNT_WIDTH-1:0]    r_cnt_lat, r_beat_cnt, r_err_cnt, r_first_idx;
  logic [AXI_CHNL_NUM-1:0] r_first_lane;
  logic [DW-1:0]           r_first_data;
  logic                    r_first_vld;
  logic [1:0]              r_flags, r_sts;
  logic [TMO_WIDTH-1:0]    r_tmo;

  logic                    w_start, w_run, w_tready, w_accept, w_bad_beat;
  logic                    w_complete, w_timeout, w_pass;
  logic                    w_fifo_empty, w_fifo_full, w_fifo_ovf;
  logic [DW-1:0]           w_exp;
  logic [AXI_CHNL_NUM-1:0] w_mism;
  logic [CNT_WIDTH-1:0]    w_beat_inc;
  logic [TMO_WIDTH-1:0]    w_tmo_inc;

  axi_st_h2h_sync_fifo #(.WIDTH(DW), .DEPTH(EXP_FIFO_DEPTH)) u_exp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (~bus.chk_en),
    .i_wr    (bus.exp_wr),
    .i_din   (bus.exp_din),
    .i_rd    (w_accept),
    .o_dout  (w_exp),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_ovf   (w_fifo_ovf)
  );

  generate
    for (genvar gi = 0; gi < AXI_CHNL_NUM; gi++) begin : g_lane
      assign w_mism[gi] = bus.lane_mask[gi] & (bus.axist_tdata[64*gi +: 64] != w_exp[64*gi +: 64]);
    end
  endgenerate

  assign w_start    = bus.chk_en & ~r_chk_en_d;
  assign w_run      = (r_state == RUN) & bus.chk_en;
  assign w_accept   = w_tready & bus.axist_tvalid;
  assign w_bad_beat = w_accept & (|w_mism);
  assign w_beat_inc = r_beat_cnt + 1'b1;
  assign w_tmo_inc  = r_tmo + 1'b1;
  // A zero latched count completes on the first RUN cycle since beat_cnt already matches.
  assign w_complete = w_run & (w_accept ? (w_beat_inc == r_cnt_lat) : (r_beat_cnt == r_cnt_lat));
  assign w_timeout  = w_run & ~w_accept & ~w_complete & (bus.tmo_limit != '0) &
                      (w_tmo_inc == bus.tmo_limit);
  assign w_pass     = (r_err_cnt == '0) & ~w_bad_beat & ~r_flags[FLG_OVF] & ~w_fifo_ovf & ~w_timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_next = RUN;
      RUN:     if (!bus.chk_en) w_state_next = IDLE;
               else if (w_complete | w_timeout) w_state_next = DONE;
      DONE:    if (!bus.chk_en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tready = 1'b0;
    if (r_state == RUN)
      w_tready = bus.chk_en & ~w_fifo_empty & (r_beat_cnt != r_cnt_lat);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chk_en_d   <= 1'b0;
      r_cnt_lat    <= '0;
      r_beat_cnt   <= '0;
      r_err_cnt    <= '0;
      r_first_vld  <= 1'b0;
      r_first_idx  <= '0;
      r_first_lane <= '0;
      r_first_data <= '0;
      r_flags      <= '0;
      r_sts        <= '0;
      r_tmo        <= '0;
    end else begin
      r_chk_en_d <= bus.chk_en;
      if (r_state == IDLE && w_start) begin
        r_cnt_lat    <= bus.chk_cnt;
        r_beat_cnt   <= '0;
        r_err_cnt    <= '0;
        r_first_vld  <= 1'b0;
        r_first_idx  <= '0;
        r_first_lane <= '0;
        r_first_data <= '0;
        r_flags      <= '0;
        r_sts        <= '0;
        r_tmo        <= '0;
      end else if (w_run) begin
        if (w_accept) begin
          r_beat_cnt <= w_beat_inc;
          r_tmo      <= '0;
        end else begin
          r_tmo <= w_tmo_inc;
        end
        if (w_bad_beat) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
          if (!r_first_vld) begin
            r_first_vld  <= 1'b1;
            r_first_idx  <= r_beat_cnt;
            r_first_lane <= w_mism;
            r_first_data <= bus.axist_tdata;
          end
        end
        if (w_fifo_ovf) r_flags[FLG_OVF] <= 1'b1;
        if (w_timeout)  r_flags[FLG_TMO] <= 1'b1;
        if (w_complete | w_timeout) begin
          r_sts[STS_DONE_BIT] <= 1'b1;
          r_sts[STS_PASS_BIT] <= w_pass;
        end
      end
    end
  end

  assign bus.exp_fifo_full  = w_fifo_full;
  assign bus.axist_tready   = w_tready;
  assign bus.chk_status     = r_sts;
  assign bus.beat_cnt       = r_beat_cnt;
  assign bus.err_cnt        = r_err_cnt;
  assign bus.first_err_vld  = r_first_vld;
  assign bus.first_err_idx  = r_first_idx;
  assign bus.first_err_lane = r_first_lane;
  assign bus.first_err_data = r_first_data;
  assign bus.flags          = r_flags;

endmodule
